// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output-side stream logic.
//   - state_t      : frame tracker FSM encoding
//   - CONV_DATA_W  : default result word width
//   - CONV_CNT_W   : default position counter / frame size width
package conv_pkg;

    localparam int CONV_DATA_W = 32;
    localparam int CONV_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row wrap-around position counter for a runtime-sized frame.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   clr                   : force position back to (0,0)
//   en                    : advance one pixel position
//   width, height         : frame size in pixels (must be >= 1)
//   col, row              : current position
//   end_of_line           : col is the last column of the row
//   end_of_frame          : position is the last pixel of the frame
module conv_pos_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             end_of_line,
    output logic             end_of_frame
);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    assign col          = col_q;
    assign row          = row_q;
    assign end_of_line  = (col_q == width - CNT_W'(1));
    assign end_of_frame = end_of_line && (row_q == height - CNT_W'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (!end_of_line) begin
                col_d = col_q + CNT_W'(1);
            end else begin
                col_d = '0;
                // Wrap the row too at frame end so it never reaches height.
                row_d = end_of_frame ? '0 : row_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv_out_stream_tracker.sv
// Output-side frame tracker for the streaming convolution core. Follows the
// pixel position of each raw result, drops border results whose KxK window
// is incomplete and forwards the rest through a single output register with
// end-of-line / end-of-frame markers.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_width/height  : frame start and size (0 treated as 1)
//   in_valid/in_ready/in_data: raw result stream, one per pixel
//   out_valid/out_ready/out_data/out_eol/out_last : filtered result stream
//   busy, frame_done         : status; frame_done is a one-cycle pulse
// Optional build macro CONV_OUT_STATS_EN adds emitted_cnt / dropped_cnt
// saturating statistics counters, cleared on accepted start.
//
// state | meaning
// IDLE  | waiting for start, no input accepted
// RUN   | consuming results, tracking position
// DRAIN | all pixels consumed, waiting for output register to empty
module conv_out_stream_tracker
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int CNT_W  = CONV_CNT_W,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
`ifdef CONV_OUT_STATS_EN
    ,
    output logic [CNT_W*2-1:0] emitted_cnt,
    output logic [CNT_W*2-1:0] dropped_cnt
`endif
);

    localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  w_q, w_d, h_q, h_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_eol_q, out_eol_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;

    logic [CNT_W-1:0]  col, row;
    logic              eol, eof;
    logic              start_acc, fire, win_ok, load, drain;

    assign start_acc = (state_q == IDLE) && start;
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign fire      = in_valid && in_ready;
    assign win_ok    = (col >= KM1) && (row >= KM1);
    assign load      = fire && win_ok;
    assign drain     = out_valid_q && out_ready;

    conv_pos_counter #(.CNT_W(CNT_W)) u_pos (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_acc),
        .en           (fire),
        .width        (w_q),
        .height       (h_q),
        .col          (col),
        .row          (row),
        .end_of_line  (eol),
        .end_of_frame (eof)
    );

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_eol_d    = out_eol_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
                    h_d     = (cfg_height == '0) ? CNT_W'(1) : cfg_height;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fire && eof) state_d = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Drain first so a same-cycle load leaves the new word in place.
        if (drain) out_valid_d = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_eol_d   = eol;
            out_last_d  = eof;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_eol    = out_eol_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

`ifdef CONV_OUT_STATS_EN
    logic [CNT_W*2-1:0] emitted_q, emitted_d;
    logic [CNT_W*2-1:0] dropped_q, dropped_d;

    always_comb begin
        emitted_d = emitted_q;
        dropped_d = dropped_q;
        if (start_acc) begin
            emitted_d = '0;
            dropped_d = '0;
        end else begin
            if (drain && !(&emitted_q))        emitted_d = emitted_q + (CNT_W*2)'(1);
            if (fire && !win_ok && !(&dropped_q)) dropped_d = dropped_q + (CNT_W*2)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            emitted_q <= '0;
            dropped_q <= '0;
        end else begin
            emitted_q <= emitted_d;
            dropped_q <= dropped_d;
        end
    end

    assign emitted_cnt = emitted_q;
    assign dropped_cnt = dropped_q;
`endif

endmodule

// File: tb/tb_conv_out_stream_tracker.sv
module tb_conv_out_stream_tracker;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int K      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  cfg_width, cfg_height;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol, out_last;
    logic              busy, frame_done;
`ifdef CONV_OUT_STATS_EN
    logic [CNT_W*2-1:0] emitted_cnt, dropped_cnt;
`endif

    conv_out_stream_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_eol    (out_eol),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CONV_OUT_STATS_EN
        ,
        .emitted_cnt (emitted_cnt),
        .dropped_cnt (dropped_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              eol;
        logic              last;
    } exp_t;

    // mode 0: ready always high, data = pixel index
    // mode 1: ready pattern 1,0,0,1, data = pixel index
    // mode 2: random valid/ready/data, stray start pulses mid-frame
    task automatic run_frame(input int cw, input int ch, input int mode);
        int w, h, n, consumed, outs, cyc, last_fire, last_hs, done_cyc, done_cnt, exp_outs, exp_done;
        logic [DATA_W-1:0] data[];
        exp_t q[$];
        exp_t e, pend;
        logic pend_chk, prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [3:0] rdy_pat;

        w = (cw == 0) ? 1 : cw;
        h = (ch == 0) ? 1 : ch;
        n = w * h;
        exp_outs = (w >= K && h >= K) ? (w - K + 1) * (h - K + 1) : 0;
        data = new[n];
        for (int i = 0; i < n; i++) data[i] = (mode == 2) ? DATA_W'($urandom) : DATA_W'(i);
        rdy_pat = 4'b1001;

        @(posedge clk); #1;
        start = 1'b1; cfg_width = CNT_W'(cw); cfg_height = CNT_W'(ch);
        in_valid = 1'b0; out_ready = 1'b1;

        consumed = 0; outs = 0; cyc = 0; last_fire = -10; last_hs = -10;
        done_cyc = -1; done_cnt = 0; pend_chk = 1'b0; prev_stall = 1'b0; prev_data = '0;

        while (cyc < 2000 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 2 && consumed < n && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                cfg_width  = CNT_W'($urandom_range(0, 9));
                cfg_height = CNT_W'($urandom_range(0, 9));
            end
            in_valid  = (mode < 2) ? (consumed < n) : ($urandom_range(0, 3) != 0);
            in_data   = (consumed < n) ? data[consumed] : DATA_W'($urandom);
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? rdy_pat[cyc % 4] : ($urandom_range(0, 2) != 0);

            @(negedge clk);
`ifdef CONV_OUT_STATS_EN
            if (cyc == 0) begin
                chk("stats_emit_clr", emitted_cnt, 0);
                chk("stats_drop_clr", dropped_cnt, 0);
            end
`endif
            chk("in_ready", in_ready, (consumed < n) && (!out_valid || out_ready));
            if (done_cnt == 0 && !frame_done) chk("busy_run", busy, 1);
            if (pend_chk) begin
                chk("lat_valid", out_valid, 1);
                chk("lat_data", out_data, pend.d);
                pend_chk = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_out", out_data, 64'hdead_beef_dead_beef);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_eol", out_eol, e.eol);
                    chk("out_last", out_last, e.last);
                end
                outs++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    exp_done = (last_fire + 2 > last_hs + 1) ? last_fire + 2 : last_hs + 1;
                    chk("done_time", done_cyc, exp_done);
                end else begin
                    chk("done_pulses", done_cnt, 1);
                end
            end
            if (in_valid && in_ready) begin
                if ((consumed % w) >= K - 1 && (consumed / w) >= K - 1) begin
                    pend.d    = data[consumed];
                    pend.eol  = (consumed % w) == w - 1;
                    pend.last = consumed == n - 1;
                    q.push_back(pend);
                    pend_chk = 1'b1;
                end
                consumed++;
                last_fire = cyc;
            end
            cyc++;
        end

        in_valid = 1'b0; start = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("consumed", consumed, n);
        chk("outs", outs, exp_outs);
        chk("queue_empty", q.size(), 0);
        chk("idle_busy", busy, 0);
`ifdef CONV_OUT_STATS_EN
        chk("stats_emitted", emitted_cnt, exp_outs);
        chk("stats_dropped", dropped_cnt, n - exp_outs);
`endif
    endtask

    task automatic reset_mid_frame();
        int consumed, cyc;
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 5; cfg_height = 4; out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        consumed = 0; cyc = 0;
        while (consumed < 8 && cyc < 100) begin
            in_valid = 1'b1; in_data = DATA_W'(consumed);
            @(negedge clk);
            if (in_valid && in_ready) consumed++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_consumed", consumed, 8);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_inrdy", in_ready, 0);
        chk("mid_rst_done", frame_done, 0);
        #4 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_done", frame_done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_eol", out_eol, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        run_frame(5, 4, 0);
        run_frame(5, 4, 1);
        run_frame(2, 6, 0);
        run_frame(0, 0, 0);
        run_frame(3, 3, 1);
        reset_mid_frame();
        run_frame(5, 4, 0);
        for (int f = 0; f < 12; f++) begin
            run_frame($urandom_range(0, 7), $urandom_range(0, 7), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
